qvalue_max_select: RTL and testbench

Sequential arg-max stage feeding the routing decision logic of the EER-RL node. It accepts a stream of (neighbour ID, 16-bit unsigned Q-value) entries, one per handshake. Using the same greater/equal/less ordering as the 16-bit comparator, it keeps the running maximum. After the entry flagged last, it presents the winning ID, its Q-value and the entry count on a held valid/ready output.

---
 rtl/qvalue_max_select.sv | 134 +++++++++++++
 tb/tb_qvalue_max_select.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/qvalue_max_select.sv
// Sequential arg-max over a stream of (neighbour ID, Q-value) entries; the winner is held on a valid/ready output.
// Optional macro QMAX_TIEBREAK_LATEST_EN: on equal Q-values the later entry wins instead of the earlier one.
module qvalue_max_select #(
    parameter int ID_W  = 8,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_q,
    input  logic [ID_W-1:0]  in_id,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_q,
    output logic [ID_W-1:0]  out_id,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q, state_d;
    logic [15:0]       best_val_q, best_val_d;
    logic [ID_W-1:0]   best_id_q, best_id_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              first_q, first_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              accept_s;
    logic              take_s;

    assign accept_s = in_valid && in_ready_q;

`ifdef QMAX_TIEBREAK_LATEST_EN
    assign take_s = first_q || (in_q >= best_val_q);
`else
    assign take_s = first_q || (in_q > best_val_q);
`endif

    // Next-state and datapath update; handshake flags follow the next state so they stay registered.
    always_comb begin
        state_d    = state_q;
        best_val_d = best_val_q;
        best_id_d  = best_id_q;
        count_d    = count_q;
        first_d    = first_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SCAN;
                    best_val_d = 16'd0;
                    best_id_d  = '0;
                    count_d    = '0;
                    first_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (accept_s) begin
                    if (count_q == CNT_MAX) begin
                        count_d = count_q;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                    if (take_s) begin
                        best_val_d = in_q;
                        best_id_d  = in_id;
                    end else begin
                        best_val_d = best_val_q;
                        best_id_d  = best_id_q;
                    end
                    first_d = 1'b0;
                    if (in_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_SCAN);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            best_val_q  <= 16'd0;
            best_id_q   <= '0;
            count_q     <= '0;
            first_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            best_val_q  <= best_val_d;
            best_id_q   <= best_id_d;
            count_q     <= count_d;
            first_q     <= first_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_q     = best_val_q;
    assign out_id    = best_id_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_qvalue_max_select.sv
// Directed bench for qvalue_max_select: inputs change and outputs are sampled on the falling edge.
module tb_qvalue_max_select;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_q;
    logic [7:0]  in_id;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_q;
    logic [7:0]  out_id;
    logic [8:0]  out_count;

    int checks_r = 0;
    int errors_r = 0;

    qvalue_max_select #(.ID_W(8), .CNT_W(9)) dut (
        .clk(clk), .nrst(nrst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q), .in_id(in_id), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_id(out_id), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("ready_after_start", 32'(in_ready), 32'd1);
    endtask

    task automatic send_entry(input logic [7:0] id, input logic [15:0] q, input logic last);
        int n;
        in_valid = 1'b1;
        in_id    = id;
        in_q     = q;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_val("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("drain_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [7:0] id, input logic [15:0] q,
                                input logic [8:0] cnt);
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_ready"}, 32'(in_ready), 32'd0);
        check_val({tag, "_id"}, 32'(out_id), 32'(id));
        check_val({tag, "_q"}, 32'(out_q), 32'(q));
        check_val({tag, "_count"}, 32'(out_count), 32'(cnt));
    endtask

    initial begin
        logic [7:0] tie_id;
        nrst = 1'b0; start = 1'b0; in_valid = 1'b1; in_q = 16'hABCD; in_id = 8'h77;
        in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_ready", 32'(in_ready), 32'd0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_q", 32'(out_q), 32'd0);
        check_val("rst_id", 32'(out_id), 32'd0);
        check_val("rst_count", 32'(out_count), 32'd0);
        nrst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check_val("idle_ready", 32'(in_ready), 32'd0);

        // Basic maximum
        do_start();
        send_entry(8'd1, 16'h0100, 1'b0);
        send_entry(8'd2, 16'h7FFF, 1'b0);
        check_val("basic_not_done", 32'(out_valid), 32'd0);
        send_entry(8'd3, 16'h0042, 1'b1);
        check_result("basic", 8'd2, 16'h7FFF, 9'd3);
        drain();
        check_val("idle_hold_id", 32'(out_id), 32'd2);
        check_val("idle_hold_count", 32'(out_count), 32'd3);

        // Equal Q-values
`ifdef QMAX_TIEBREAK_LATEST_EN
        tie_id = 8'd6;
`else
        tie_id = 8'd5;
`endif
        do_start();
        send_entry(8'd5, 16'h0200, 1'b0);
        send_entry(8'd6, 16'h0200, 1'b1);
        check_result("tie", tie_id, 16'h0200, 9'd2);
        drain();

        // Single zero entry, backpressure, start ignored in DONE
        do_start();
        send_entry(8'd9, 16'h0000, 1'b1);
        check_result("single", 8'd9, 16'h0000, 9'd1);
        for (int i = 0; i < 5; i++) begin
            start = (i == 1);
            @(negedge clk);
            check_val("bp_valid", 32'(out_valid), 32'd1);
            check_val("bp_id", 32'(out_id), 32'd9);
            check_val("bp_count", 32'(out_count), 32'd1);
        end
        start = 1'b0;
        check_result("bp_end", 8'd9, 16'h0000, 9'd1);
        drain();

        // Abort by reset mid-scan
        do_start();
        send_entry(8'd7, 16'h0500, 1'b0);
        send_entry(8'd8, 16'h0600, 1'b0);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        check_val("abort_ready", 32'(in_ready), 32'd0);
        check_val("abort_valid", 32'(out_valid), 32'd0);
        check_val("abort_q", 32'(out_q), 32'd0);
        check_val("abort_id", 32'(out_id), 32'd0);
        check_val("abort_count", 32'(out_count), 32'd0);
        do_start();
        send_entry(8'd4, 16'hFFFF, 1'b1);
        check_result("after_abort", 8'd4, 16'hFFFF, 9'd1);
        drain();

        // Stalled stream: idle beats carry a large Q that must not be taken
        do_start();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_id    = 8'(8'd10 + i);
            in_q     = 16'(16'h0010 * (i + 1));
            in_last  = (i == 3);
            check_val("stall_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_id    = 8'hEE;
            in_q     = 16'hFFFF;
            if (i < 3) begin
                @(negedge clk);
            end
        end
        check_result("stall", 8'd13, 16'h0040, 9'd4);
        drain();

        // Counter saturation over a long ascending stream
        do_start();
        for (int i = 0; i < 515; i++) begin
            in_valid = 1'b1;
            in_id    = 8'(i);
            in_q     = 16'(i);
            in_last  = (i == 514);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("sat", 8'h02, 16'd514, 9'd511);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
